param_step_counter: RTL

PARAM_STEP_COUNTER -- requirements
Module: param_step_counter

---
 rtl/param_step_counter.sv | 91 +++++++++
 1 files changed

// File: rtl/param_step_counter.sv
// param_step_counter
//
// Up/down counter with a programmable step, a synchronous parallel load, and a
// choice of wrap-around or saturating behaviour at the range limits.
//
// Parameters
//   WIDTH  : count register width in bits (2..32)
//   STEPW  : step input width in bits (1..WIDTH)
//   SAT_EN : 1 = saturate at 0 / all-ones, 0 = wrap modulo 2^WIDTH
//
// Ports
//   clk  : in  clock; all state changes on the rising edge
//   rst  : in  synchronous active-high reset (q=0, ovf=0)
//   en   : in  count enable
//   dn   : in  direction, 0 = up, 1 = down
//   step : in  unsigned step magnitude (0 = hold)
//   ld   : in  parallel load strobe, loads d into q
//   d    : in  load value
//   q    : out registered count
//   ovf  : out registered pulse, high for the cycle after an overflow/underflow
//   tc   : out combinational terminal count (q all-ones going up, q zero going down)
//
// Priority per edge: rst > ld > en > hold.

module param_step_counter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEPW  = 4,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dn,
    input  logic [STEPW-1:0] step,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             tc
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;

    // One extra bit holds the carry (up) or borrow (down) of the ripple add/sub.
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic             carry;

    always_comb begin
        step_ext = (WIDTH + 1)'(step);
        if (dn) begin
            sum = {1'b0, q_q} - step_ext;
        end else begin
            sum = {1'b0, q_q} + step_ext;
        end
        carry = sum[WIDTH];
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (ld) begin
            q_d = d;
        end else if (en) begin
            ovf_d = carry;
            if (SAT_EN && carry) begin
                // Clamp to the limit in the direction of travel.
                q_d = dn ? '0 : '1;
            end else begin
                q_d = sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
    // Depends on the live dn input, so there is deliberately no register here.
    assign tc  = dn ? (q_q == '0) : (q_q == '1);

endmodule
